// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Producer-side controller for the ID/EX pipeline register. Detects
//   load-use hazards between the IF/ID instruction and the load sitting in
//   ID/EX. Handles taken-branch flushes. Sequences multi-cycle stalls and
//   flushes. Keeps saturating event counters for performance debug.
//
// Parameters
//   STALL_CYCLES  total cycles held per load-use hazard (1..15)
//   FLUSH_CYCLES  total cycles of flush per taken branch (1..15)
//   CNT_W         width of the stall / flush event counters
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   ifid_valid      IF/ID holds a real instruction
//   ifid_rs1/rs2    source register fields of the IF/ID instruction
//   idex_memread    ID/EX holds a load
//   idex_rd         destination register of the ID/EX instruction
//   branch_taken    branch resolved taken in EX this cycle
//   pc_write        PC update enable
//   ifid_write      IF/ID load enable
//   ifid_flush      clear IF/ID to NOP
//   idex_bubble     select all-zero control inputs into ID/EX
//   state           0=RUN, 1=STALL, 2=FLUSH
//   stall_count     cycles with pc_write=0 (saturating)
//   flush_count     cycles with ifid_flush=1 (saturating)
module hazard_stall_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifid_valid,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // rem holds the cycles still to go after the current one.
  localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [3:0]       rem_reg, rem_next;
  logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

  logic hz;
  logic do_flush;
  logic do_stall;

  // x0 is never a real destination, so a load to x0 never stalls.
  assign hz = ifid_valid & idex_memread & (idex_rd != 5'd0) &
              ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  // A taken branch wins over everything; an ongoing flush ignores hz and
  // the STALL state ignores hz as well (the hold is already committed).
  assign do_flush = (state_reg == FLUSH) | branch_taken;
  assign do_stall = ~do_flush & ((state_reg == STALL) | hz);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      // Hold the front end and keep ID/EX harmless while in reset.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (do_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (do_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    case (state_reg)
      STALL: begin
        if (branch_taken) begin
          // Redirect aborts the stall and starts a fresh flush.
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            rem_next   = FLUSH_RELOAD;
          end else begin
            state_next = RUN;
            rem_next   = 4'd0;
          end
        end else if (rem_reg <= 4'd1) begin
          state_next = RUN;
          rem_next   = 4'd0;
        end else begin
          rem_next = rem_reg - 4'd1;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          rem_next = FLUSH_RELOAD;
        end else if (rem_reg <= 4'd1) begin
          state_next = RUN;
          rem_next   = 4'd0;
        end else begin
          rem_next = rem_reg - 4'd1;
        end
      end
      default: begin
        // RUN (and the unused encoding, which recovers as RUN).
        state_next = RUN;
        if (branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            rem_next   = FLUSH_RELOAD;
          end
        end else if (hz) begin
          if (STALL_CYCLES > 1) begin
            state_next = STALL;
            rem_next   = STALL_RELOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      rem_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (!pc_write && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      if (ifid_flush && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + CNT_W'(1);
    end
  end

  assign state       = state_reg;
  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Drives several differently-parameterised controllers with the same input
// stream. A reference model built on "cycles of stall/flush still owed"
// predicts each cycle's response; expectations go into a queue and a
// separate monitor pops and compares them in the middle of the low phase.
module tb_hazard_stall_ctrl;

  localparam int NCFG = 4;
  localparam int SC_T [NCFG] = '{1, 3, 4, 2};
  localparam int FC_T [NCFG] = '{2, 5, 2, 1};
  localparam int W_T  [NCFG] = '{16, 16, 3, 16};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ifid_valid = 1'b0;
  logic [4:0] ifid_rs1 = 5'd0;
  logic [4:0] ifid_rs2 = 5'd0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = 5'd0;
  logic       branch_taken = 1'b0;

  logic        pcw_w [NCFG];
  logic        ifw_w [NCFG];
  logic        fl_w  [NCFG];
  logic        bub_w [NCFG];
  logic [1:0]  st_w  [NCFG];
  logic [15:0] sc_w  [NCFG];
  logic [15:0] fc_w  [NCFG];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int W = W_T[gi];
    logic         pcw_l, ifw_l, fl_l, bub_l;
    logic [1:0]   st_l;
    logic [W-1:0] sc_l, fc_l;

    hazard_stall_ctrl #(
      .STALL_CYCLES(SC_T[gi]),
      .FLUSH_CYCLES(FC_T[gi]),
      .CNT_W       (W)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .ifid_valid  (ifid_valid),
      .ifid_rs1    (ifid_rs1),
      .ifid_rs2    (ifid_rs2),
      .idex_memread(idex_memread),
      .idex_rd     (idex_rd),
      .branch_taken(branch_taken),
      .pc_write    (pcw_l),
      .ifid_write  (ifw_l),
      .ifid_flush  (fl_l),
      .idex_bubble (bub_l),
      .state       (st_l),
      .stall_count (sc_l),
      .flush_count (fc_l)
    );

    assign pcw_w[gi] = pcw_l;
    assign ifw_w[gi] = ifw_l;
    assign fl_w[gi]  = fl_l;
    assign bub_w[gi] = bub_l;
    assign st_w[gi]  = st_l;
    assign sc_w[gi]  = 16'(sc_l);
    assign fc_w[gi]  = 16'(fc_l);
  end

  typedef struct packed {
    logic [NCFG-1:0]       pcw;
    logic [NCFG-1:0]       ifw;
    logic [NCFG-1:0]       fl;
    logic [NCFG-1:0]       bub;
    logic [NCFG-1:0][1:0]  st;
    logic [NCFG-1:0][15:0] sc;
    logic [NCFG-1:0][15:0] fc;
  } exp_t;

  exp_t exp_q [$];

  // Reference model: how many more cycles of flush / stall are owed after
  // the current one, and unbounded event tallies (saturation applied on read).
  int flush_left [NCFG];
  int stall_left [NCFG];
  int n_stall    [NCFG];
  int n_flush    [NCFG];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  function automatic logic [15:0] sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return 16'((n > m) ? m : n);
  endfunction

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL txn %0d cfg %0d %s: got %0d expected %0d", n_txn, c, nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model predicts this cycle's outputs and
  // then advances across the following rising edge.
  task automatic cycle(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic rs);
    exp_t e;
    logic hz, fl, stl;
    @(negedge clk);
    reset        = rs;
    ifid_valid   = v;
    ifid_rs1     = r1;
    ifid_rs2     = r2;
    idex_memread = mr;
    idex_rd      = rd;
    branch_taken = br;
    hz = v & mr & (rd != 5'd0) & ((rd == r1) | (rd == r2));
    e = '0;
    for (int c = 0; c < NCFG; c++) begin
      if (rs) begin
        flush_left[c] = 0;
        stall_left[c] = 0;
        n_stall[c]    = 0;
        n_flush[c]    = 0;
        e.pcw[c] = 1'b0;
        e.ifw[c] = 1'b0;
        e.fl[c]  = 1'b1;
        e.bub[c] = 1'b1;
        e.st[c]  = 2'd0;
        e.sc[c]  = 16'd0;
        e.fc[c]  = 16'd0;
      end else begin
        fl  = br || (flush_left[c] > 0);
        stl = !fl && ((stall_left[c] > 0) || hz);
        e.st[c]  = (flush_left[c] > 0) ? 2'd2 : ((stall_left[c] > 0) ? 2'd1 : 2'd0);
        e.sc[c]  = sat(n_stall[c], W_T[c]);
        e.fc[c]  = sat(n_flush[c], W_T[c]);
        e.pcw[c] = !stl;
        e.ifw[c] = !stl;
        e.fl[c]  = fl;
        e.bub[c] = fl || stl;
        if (stl) n_stall[c]++;
        if (fl)  n_flush[c]++;
        if (br) begin
          flush_left[c] = FC_T[c] - 1;
          stall_left[c] = 0;
        end else if (flush_left[c] > 0) begin
          flush_left[c]--;
        end else if (stall_left[c] > 0) begin
          stall_left[c]--;
        end else if (hz) begin
          stall_left[c] = SC_T[c] - 1;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compare whatever the DUTs present against the oldest expectation.
  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        n_txn++;
        $display("txn %0d rst=%0b br=%0b | cfg0 st=%0d pcw=%0b fl=%0b sc=%0d fc=%0d",
                 n_txn, reset, branch_taken, st_w[0], pcw_w[0], fl_w[0], sc_w[0], fc_w[0]);
        for (int c = 0; c < NCFG; c++) begin
          chk("pc_write",    c, int'(pcw_w[c]), int'(me.pcw[c]));
          chk("ifid_write",  c, int'(ifw_w[c]), int'(me.ifw[c]));
          chk("ifid_flush",  c, int'(fl_w[c]),  int'(me.fl[c]));
          chk("idex_bubble", c, int'(bub_w[c]), int'(me.bub[c]));
          chk("state",       c, int'(st_w[c]),  int'(me.st[c]));
          chk("stall_count", c, int'(sc_w[c]),  int'(me.sc[c]));
          chk("flush_count", c, int'(fc_w[c]),  int'(me.fc[c]));
        end
      end
    end
  end

  initial begin : stimulus
    logic v, mr, br, rs;
    logic [4:0] r1, r2, rd;
    for (int c = 0; c < NCFG; c++) begin
      flush_left[c] = 0;
      stall_left[c] = 0;
      n_stall[c]    = 0;
      n_flush[c]    = 0;
    end

    // Reset state.
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);

    // Load-use on rs2.
    cycle(1'b1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(5);

    // Load-use on rs1, one cycle of hazard then the load is gone.
    cycle(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    idle(5);

    // x0 load and invalid IF/ID never stall.
    cycle(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0);
    cycle(1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0);
    idle(2);

    // Branch with a concurrent hazard.
    cycle(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    idle(6);

    // Branch on the second stall cycle.
    cycle(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
    cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(8);

    // Reset asserted partway through a flush.
    cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Randomised traffic with a narrow register range to make hazards common.
    for (int i = 0; i < 2000; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      mr = $urandom_range(0, 1) == 1;
      br = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 99) == 0);
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      cycle(v, r1, r2, mr, rd, br, rs);
    end

    @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
